// File: rtl/unified_mem_arbiter.sv
// Arbitrates one instruction-fetch port and one data port onto a single memory bus.
// Optional macro ARB_RR_EN: round-robin tie-break instead of fixed data-first priority.
module unified_mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic        m_we,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_ack,
  input  logic [31:0] m_rdata,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam logic [4:0]  LP_TO_LAST = 5'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] LP_NOP     = 32'h0000_0013;

  state_t      r_state, w_state_nxt;
  logic [4:0]  r_cnt, w_cnt_nxt;
  logic        r_m_req, w_m_req_nxt;
  logic        r_m_we, w_m_we_nxt;
  logic [1:0]  r_m_size, w_m_size_nxt;
  logic [31:0] r_m_addr, w_m_addr_nxt;
  logic [31:0] r_m_wdata, w_m_wdata_nxt;
  logic        r_i_ready, w_i_ready_nxt;
  logic [31:0] r_i_rdata, w_i_rdata_nxt;
  logic        r_d_ready, w_d_ready_nxt;
  logic [31:0] r_d_rdata, w_d_rdata_nxt;
  logic        r_bus_err, w_bus_err_nxt;

  logic w_i_elig, w_d_elig, w_grant_i, w_grant_d;

  assign w_i_elig = i_req & ~r_i_ready;
  assign w_d_elig = d_req & ~r_d_ready;

`ifdef ARB_RR_EN
  // Remembers which port won the last grant; 0 = fetch, 1 = data.
  logic r_last_d, w_last_d_nxt;

  assign w_grant_d = w_d_elig & (~w_i_elig | ~r_last_d);
`else
  assign w_grant_d = w_d_elig;
`endif
  assign w_grant_i = w_i_elig & ~w_grant_d;

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_m_req_nxt   = r_m_req;
    w_m_we_nxt    = r_m_we;
    w_m_size_nxt  = r_m_size;
    w_m_addr_nxt  = r_m_addr;
    w_m_wdata_nxt = r_m_wdata;
    w_i_ready_nxt = 1'b0;
    w_i_rdata_nxt = r_i_rdata;
    w_d_ready_nxt = 1'b0;
    w_d_rdata_nxt = r_d_rdata;
    w_bus_err_nxt = r_bus_err;
`ifdef ARB_RR_EN
    w_last_d_nxt  = r_last_d;
`endif
    case (r_state)
      IDLE: begin
        if (w_grant_d) begin
          w_state_nxt   = BUSY_D;
          w_cnt_nxt     = 5'd0;
          w_m_req_nxt   = 1'b1;
          w_m_we_nxt    = d_we;
          w_m_size_nxt  = d_size;
          w_m_addr_nxt  = d_addr;
          w_m_wdata_nxt = d_wdata;
`ifdef ARB_RR_EN
          w_last_d_nxt  = 1'b1;
`endif
        end else if (w_grant_i) begin
          w_state_nxt   = BUSY_I;
          w_cnt_nxt     = 5'd0;
          w_m_req_nxt   = 1'b1;
          w_m_we_nxt    = 1'b0;
          w_m_size_nxt  = 2'b10;
          w_m_addr_nxt  = i_addr;
          w_m_wdata_nxt = 32'd0;
`ifdef ARB_RR_EN
          w_last_d_nxt  = 1'b0;
`endif
        end
      end
      BUSY_I, BUSY_D: begin
        // Ack takes precedence over a timeout landing on the same cycle.
        if (m_ack) begin
          w_m_req_nxt = 1'b0;
          w_state_nxt = IDLE;
          if (r_state == BUSY_I) begin
            w_i_ready_nxt = 1'b1;
            w_i_rdata_nxt = m_rdata;
          end else begin
            w_d_ready_nxt = 1'b1;
            w_d_rdata_nxt = m_rdata;
          end
        end else if (r_cnt == LP_TO_LAST) begin
          // Abort: fetch sees a NOP, loads see zero, error stays set until reset.
          w_m_req_nxt   = 1'b0;
          w_state_nxt   = IDLE;
          w_bus_err_nxt = 1'b1;
          if (r_state == BUSY_I) begin
            w_i_ready_nxt = 1'b1;
            w_i_rdata_nxt = LP_NOP;
          end else begin
            w_d_ready_nxt = 1'b1;
            w_d_rdata_nxt = 32'd0;
          end
        end else begin
          w_cnt_nxt = r_cnt + 5'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cnt     <= 5'd0;
      r_m_req   <= 1'b0;
      r_m_we    <= 1'b0;
      r_m_size  <= 2'b00;
      r_m_addr  <= 32'd0;
      r_m_wdata <= 32'd0;
      r_i_ready <= 1'b0;
      r_i_rdata <= 32'd0;
      r_d_ready <= 1'b0;
      r_d_rdata <= 32'd0;
      r_bus_err <= 1'b0;
`ifdef ARB_RR_EN
      r_last_d  <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_m_req   <= w_m_req_nxt;
      r_m_we    <= w_m_we_nxt;
      r_m_size  <= w_m_size_nxt;
      r_m_addr  <= w_m_addr_nxt;
      r_m_wdata <= w_m_wdata_nxt;
      r_i_ready <= w_i_ready_nxt;
      r_i_rdata <= w_i_rdata_nxt;
      r_d_ready <= w_d_ready_nxt;
      r_d_rdata <= w_d_rdata_nxt;
      r_bus_err <= w_bus_err_nxt;
`ifdef ARB_RR_EN
      r_last_d  <= w_last_d_nxt;
`endif
    end
  end

  assign m_req     = r_m_req;
  assign m_we      = r_m_we;
  assign m_size    = r_m_size;
  assign m_addr    = r_m_addr;
  assign m_wdata   = r_m_wdata;
  assign i_ready   = r_i_ready;
  assign i_rdata   = r_i_rdata;
  assign d_ready   = r_d_ready;
  assign d_rdata   = r_d_rdata;
  assign bus_err   = r_bus_err;
  assign stall_if  = i_req & ~r_i_ready;
  assign stall_mem = d_req & ~r_d_ready;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter (default fixed-priority build, TIMEOUT_CYCLES=16).
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ready;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        m_req;
  logic        m_we;
  logic [1:0]  m_size;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_ack;
  logic [31:0] m_rdata;
  logic        stall_if;
  logic        stall_mem;
  logic        bus_err;

  int n_checks = 0;
  int n_errors = 0;

  unified_mem_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ready(d_ready), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_size(m_size), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_ack(m_ack), .m_rdata(m_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One simultaneous fetch+data pair: data must be served first, then fetch.
  task automatic run_pair(input logic [31:0] dval, input logic [31:0] ival);
    i_req = 1'b1; i_addr = 32'h200;
    d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h300; d_wdata = 32'h0;
    tick();
    check("pair_first_addr", m_addr, 32'h300);
    check("pair_first_req", {31'd0, m_req}, 32'd1);
    check("pair_stall_if", {31'd0, stall_if}, 32'd1);
    m_ack = 1'b1; m_rdata = dval;
    tick();
    check("pair_d_ready", {31'd0, d_ready}, 32'd1);
    check("pair_d_rdata", d_rdata, dval);
    d_req = 1'b0; m_ack = 1'b0;
    tick();
    check("pair_second_addr", m_addr, 32'h200);
    check("pair_second_we", {31'd0, m_we}, 32'd0);
    m_ack = 1'b1; m_rdata = ival;
    tick();
    check("pair_i_ready", {31'd0, i_ready}, 32'd1);
    check("pair_i_rdata", i_rdata, ival);
    i_req = 1'b0; m_ack = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b0;
    i_req = 1'b0; i_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_size = 2'b00; d_addr = 32'h0; d_wdata = 32'h0;
    m_ack = 1'b0; m_rdata = 32'h0;
    #12;
    check("rst_m_req", {31'd0, m_req}, 32'd0);
    check("rst_m_addr", m_addr, 32'd0);
    check("rst_i_ready", {31'd0, i_ready}, 32'd0);
    check("rst_d_ready", {31'd0, d_ready}, 32'd0);
    check("rst_bus_err", {31'd0, bus_err}, 32'd0);
    reset = 1'b1;
    tick();

    // Minimum-latency fetch.
    i_req = 1'b1; i_addr = 32'h40;
    #1;
    check("f_stall_if_c0", {31'd0, stall_if}, 32'd1);
    tick();
    check("f_m_req_c1", {31'd0, m_req}, 32'd1);
    check("f_m_addr", m_addr, 32'h40);
    check("f_m_we", {31'd0, m_we}, 32'd0);
    check("f_m_size", {30'd0, m_size}, 32'd2);
    check("f_m_wdata", m_wdata, 32'd0);
    check("f_i_ready_c1", {31'd0, i_ready}, 32'd0);
    m_ack = 1'b1; m_rdata = 32'h0050_0093;
    tick();
    check("f_i_ready_c2", {31'd0, i_ready}, 32'd1);
    check("f_i_rdata", i_rdata, 32'h0050_0093);
    check("f_m_req_c2", {31'd0, m_req}, 32'd0);
    check("f_stall_if_c2", {31'd0, stall_if}, 32'd0);
    check("f_bus_err", {31'd0, bus_err}, 32'd0);
    i_req = 1'b0; m_ack = 1'b0;
    tick();
    check("f_i_ready_pulse", {31'd0, i_ready}, 32'd0);

    // Byte store with three wait cycles.
    d_req = 1'b1; d_we = 1'b1; d_size = 2'b00; d_addr = 32'h100; d_wdata = 32'hAB;
    tick();
    check("s_m_we", {31'd0, m_we}, 32'd1);
    check("s_m_size", {30'd0, m_size}, 32'd0);
    check("s_m_wdata", m_wdata, 32'hAB);
    for (int k = 0; k < 3; k++) begin
      check("s_m_addr_hold", m_addr, 32'h100);
      check("s_m_req_hold", {31'd0, m_req}, 32'd1);
      check("s_stall_mem", {31'd0, stall_mem}, 32'd1);
      tick();
    end
    check("s_m_addr_c4", m_addr, 32'h100);
    m_ack = 1'b1; m_rdata = 32'h0;
    tick();
    check("s_d_ready", {31'd0, d_ready}, 32'd1);
    check("s_stall_mem_done", {31'd0, stall_mem}, 32'd0);
    check("s_m_req_drop", {31'd0, m_req}, 32'd0);
    d_req = 1'b0; m_ack = 1'b0;
    tick();
    check("s_d_ready_pulse", {31'd0, d_ready}, 32'd0);

    // Stray ack while idle must not produce a completion.
    m_ack = 1'b1; m_rdata = 32'hDEAD_BEEF;
    tick();
    check("idle_ack_i", {31'd0, i_ready}, 32'd0);
    check("idle_ack_d", {31'd0, d_ready}, 32'd0);
    check("idle_ack_mreq", {31'd0, m_req}, 32'd0);
    m_ack = 1'b0;
    tick();

    // Two back-to-back simultaneous pairs: expected order D,I,D,I.
    run_pair(32'h11, 32'h22);
    run_pair(32'h33, 32'h44);

    // Ack arrives on the very cycle the timeout would fire: ack wins.
    d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h400;
    tick();
    for (int k = 0; k < 15; k++) tick();
    check("co_m_req_c16", {31'd0, m_req}, 32'd1);
    m_ack = 1'b1; m_rdata = 32'h5555_AAAA;
    tick();
    check("co_d_ready", {31'd0, d_ready}, 32'd1);
    check("co_d_rdata", d_rdata, 32'h5555_AAAA);
    check("co_bus_err", {31'd0, bus_err}, 32'd0);
    d_req = 1'b0; m_ack = 1'b0;
    tick();

    // Data timeout with no ack at all.
    d_req = 1'b1; d_addr = 32'h404;
    tick();
    for (int k = 0; k < 15; k++) tick();
    check("to_m_req_c16", {31'd0, m_req}, 32'd1);
    check("to_no_err_yet", {31'd0, bus_err}, 32'd0);
    tick();
    check("to_m_req_drop", {31'd0, m_req}, 32'd0);
    check("to_d_ready", {31'd0, d_ready}, 32'd1);
    check("to_d_rdata", d_rdata, 32'd0);
    check("to_bus_err", {31'd0, bus_err}, 32'd1);
    d_req = 1'b0;
    tick();
    tick();
    check("to_bus_err_sticky", {31'd0, bus_err}, 32'd1);

    // Asynchronous reset in the second BUSY_I cycle, fetch held across it.
    i_req = 1'b1; i_addr = 32'h500;
    tick();
    tick();
    check("ar_busy_m_req", {31'd0, m_req}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("ar_m_req_clr", {31'd0, m_req}, 32'd0);
    check("ar_m_addr_clr", m_addr, 32'd0);
    check("ar_i_ready_clr", {31'd0, i_ready}, 32'd0);
    check("ar_bus_err_clr", {31'd0, bus_err}, 32'd0);
    #1 reset = 1'b1;
    tick();
    check("ar_regrant_req", {31'd0, m_req}, 32'd1);
    check("ar_regrant_addr", m_addr, 32'h500);
    m_ack = 1'b1; m_rdata = 32'h1234_5678;
    tick();
    check("ar_i_ready", {31'd0, i_ready}, 32'd1);
    check("ar_i_rdata", i_rdata, 32'h1234_5678);
    i_req = 1'b0; m_ack = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
UNIFIED_MEM_ARBITER -- requirements
Module: unified_mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: maximum BUSY cycles waiting for m_ack before abort.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port i_req  input  1  fetch request, held with i_addr stable until i_ready.
REQ-005 SHALL have port i_addr  input  32  fetch byte address.
REQ-006 SHALL have port i_ready  output  1  one-cycle completion pulse for fetch.
REQ-007 SHALL have port i_rdata  output  32  fetched instruction, valid while i_ready=1.
REQ-008 SHALL have port d_req  input  1  data request, held with d_we/d_size/d_addr/d_wdata stable until d_ready.
REQ-009 SHALL have ports d_we  input  1  write enable; d_size  input  2  00 byte, 01 half, 10 word; d_addr  input  32; d_wdata  input  32.
REQ-010 SHALL have port d_ready  output  1  one-cycle completion pulse for data.
REQ-011 SHALL have port d_rdata  output  32  load data, valid while d_ready=1.
REQ-012 SHALL have ports m_req  output  1; m_we  output  1; m_size  output  2; m_addr  output  32; m_wdata  output  32  all registered.
REQ-013 SHALL have ports m_ack  input  1  memory completion; m_rdata  input  32  read data valid with m_ack.
REQ-014 SHALL have ports stall_if  output  1; stall_mem  output  1; bus_err  output  1.

Function
REQ-015 SHALL implement states IDLE, BUSY_I, BUSY_D.
REQ-016 In IDLE, eligible requesters SHALL be those with req=1 whose ready is 0 that cycle.
REQ-017 In IDLE, with only one eligible requester, that requester SHALL be granted; with both eligible, per REQ-030/031.
REQ-018 On grant, the request SHALL be latched onto m_* at the same edge, with m_req=1 and the next state BUSY_I or BUSY_D.
REQ-019 A fetch grant SHALL drive m_we=0, m_size=2'b10, m_wdata=0.
REQ-020 In BUSY_x, m_* SHALL hold constant until m_ack=1 is sampled.
REQ-021 On m_ack=1 in BUSY_x: x_rdata<=m_rdata, x_ready<=1 for one cycle, m_req<=0, state<=IDLE.
REQ-022 Minimum latency SHALL be: req seen cycle 0, m_req cycle 1, ack cycle 1, x_ready cycle 2.
REQ-023 A 5-bit BUSY counter SHALL clear on grant and increment each BUSY cycle without ack.
REQ-024 If the counter equals TIMEOUT_CYCLES-1 without ack, the block SHALL abort: m_req<=0, x_ready<=1, x_rdata<=32'h0000_0013 for fetch or 0 for data, bus_err<=1 (sticky), state<=IDLE.
REQ-025 If m_ack and timeout coincide, ack SHALL win and no error SHALL be flagged.
REQ-026 stall_if SHALL equal i_req & ~i_ready, and stall_mem SHALL equal d_req & ~d_ready (combinational).
REQ-027 m_ack sampled in IDLE SHALL be ignored.

Reset
REQ-028 reset=0 SHALL immediately force state IDLE, counter 0, bus_err 0, and all registered outputs (m_*, i_ready, d_ready, i_rdata, d_rdata) to 0, including mid-transaction.
REQ-029 After reset release, the first eligible request SHALL be granted on the first rising edge with reset=1.

Configuration
REQ-030 Without ARB_RR_EN defined, simultaneous eligible requests SHALL grant data (fixed priority D>I).
REQ-031 With ARB_RR_EN defined, a last_grant register (reset value I) SHALL make simultaneous requests grant the port not granted last; last_grant SHALL update on every grant.

Verification
REQ-032 i_req=1, i_addr=0x40, m_ack on first BUSY cycle, m_rdata=0x00500093 -> m_req cycle 1, i_ready=1 with i_rdata=0x00500093 cycle 2, bus_err=0.
REQ-033 d_req=1, d_we=1, d_size=00, d_addr=0x100, d_wdata=0xAB, ack after 3 wait cycles -> m_we=1, m_size=00, m_addr=0x100 held 4 cycles, d_ready one cycle, stall_mem high until d_ready.
REQ-034 i_req and d_req rise together twice back-to-back -> default build: D,I,D,I order; ARB_RR_EN build after reset: D then I.
REQ-035 d_req, m_ack never asserted, TIMEOUT_CYCLES=16 -> m_req drops after 16 BUSY cycles, d_ready=1, d_rdata=0, bus_err=1 until reset.
REQ-036 reset driven low in the second BUSY_I cycle -> m_req, i_ready and state cleared without a clock edge; after release, a held i_req is re-granted on the next edge.
